// File: rtl/mainfsm_pkg.sv
// mainfsm_pkg -- shared definitions for the multicycle main controller.
//
// Holds the controller state enumeration (4-bit encoding), the operand and
// result multiplexer select codes used by both the datapath and the decoder,
// the instruction class opcodes, and a helper that maps Op/Funct to the
// state entered after DECODE.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  // ALU operand A select
  localparam logic [1:0] SRCA_REG   = 2'b00;  // register A
  localparam logic [1:0] SRCA_PC    = 2'b01;  // program counter

  // ALU operand B select
  localparam logic [1:0] SRCB_WDATA = 2'b00;  // register WriteData
  localparam logic [1:0] SRCB_IMM   = 2'b01;  // extended immediate
  localparam logic [1:0] SRCB_FOUR  = 2'b10;  // constant 4

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;  // registered ALU output
  localparam logic [1:0] RES_DATA   = 2'b01;  // memory read data
  localparam logic [1:0] RES_ALURES = 2'b10;  // live ALU result

  // Instruction classes (Instr[27:26])
  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;
  localparam logic [1:0] OP_UND     = 2'b11;

  // State entered after DECODE. Funct[5] is the immediate flag for
  // data-processing instructions.
  function automatic state_t decode_target(input logic [1:0] op,
                                           input logic       imm_flag);
    state_t s;
    case (op)
      OP_MEM:  s = S_MEMADR;
      OP_DP:   s = imm_flag ? S_EXECUTEI : S_EXECUTER;
      OP_BR:   s = S_BRANCH;
      default: s = S_UNKNOWN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mainfsm_outdec.sv
// mainfsm_outdec -- combinational Moore output decoder for mainfsm.
//
// Ports:
//   state     : current controller state
//   mready    : MemReady, already gated low while the controller is in reset
//   IRWrite   : instruction register enable
//   AdrSrc    : memory address select (0=PC, 1=ALUOut)
//   ALUSrcA   : ALU operand A select
//   ALUSrcB   : ALU operand B select
//   ResultSrc : result bus select
//   NextPC, RegW, MemW, Branch, ALUOp : requests to the condition logic
//   Illegal   : undefined opcode trap
//
// Every output defaults to 0; each state only lists what it raises.
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  state_t     state,
  input  logic       mready,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       Illegal
);

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_WDATA;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    Illegal   = 1'b0;

    case (state)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle, but the IR and PC only
        // capture it on the cycle memory actually delivers the word.
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mready;
        NextPC    = mready;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_IMM;
      end
      S_MEMRD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        // The store is committed only on the completing cycle, so MemW
        // pulses exactly once however long memory stalls.
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemW      = mready;
      end
      S_EXECUTER: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_WDATA;
        ALUOp     = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = 1'b1;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegW      = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        Branch    = 1'b1;
      end
      default: begin
        // UNKNOWN, and any unused encoding, behaves as the trap state.
        Illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// mainfsm -- main control FSM of a multicycle ARM-style processor.
//
// Ports:
//   clk       : clock, all state changes on its rising edge
//   reset     : asynchronous active-low reset, forces FETCH
//   Op        : Instr[27:26], instruction class
//   Funct     : Instr[25:20]; bit 5 = immediate, bit 0 = load/store select
//   MemReady  : memory access completes this cycle
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc : datapath controls
//   NextPC, RegW, MemW, Branch, ALUOp : requests to the condition logic
//   Illegal   : undefined opcode trap, sticky until reset
//
// The state register and next-state logic live here; output decoding is
// done by mainfsm_outdec.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       Illegal
);

  state_t state_reg;
  state_t state_next;
  logic   mready_gated;

  // Funct[4:1] carry ALU/condition detail that is decoded elsewhere.
  logic   unused_funct;
  assign unused_funct = ^Funct[4:1];

  // While reset is held the state is already FETCH, but a high MemReady
  // must not raise IRWrite/NextPC, so gate it with the reset level.
  assign mready_gated = MemReady & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE:   state_next = decode_target(Op, Funct[5]);
      S_MEMADR:   state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWR:    state_next = MemReady ? S_FETCH : S_MEMWR;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      // UNKNOWN and unused encodings trap until reset.
      default:    state_next = S_UNKNOWN;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state     (state_reg),
    .mready    (mready_gated),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .Illegal   (Illegal)
  );

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm -- scoreboard bench for mainfsm.
//
// Stimulus walks whole instructions cycle by cycle. For every cycle it
// pushes the output word the instruction class requires in that phase of
// its execution; a separate monitor pops and compares at each falling edge.
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

  mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .MemReady  (MemReady),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .Illegal   (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] vec;
    string       tag;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cycle_no = 0;
  logic [1:0] cur_op;
  logic [5:0] cur_funct;

  // Output word: {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
  //               NextPC, RegW, MemW, Branch, ALUOp, Illegal}
  function automatic logic [13:0] ev(input logic irw, input logic adr,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic npc,
                                     input logic rw, input logic mw,
                                     input logic br, input logic aop,
                                     input logic ill);
    return {irw, adr, sa, sb, rs, npc, rw, mw, br, aop, ill};
  endfunction

  function automatic logic [13:0] v_fetch(input logic mr);
    return ev(mr, 1'b0, 2'b01, 2'b10, 2'b10, mr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [13:0] v_decode();
    return ev(1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [13:0] v_memadr();
    return ev(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [13:0] v_memrd();
    return ev(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [13:0] v_memwb();
    return ev(1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [13:0] v_memwr(input logic mr);
    return ev(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, mr, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [13:0] v_exec(input logic imm);
    return ev(1'b0, 1'b0, 2'b00, imm ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [13:0] v_aluwb();
    return ev(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [13:0] v_branch();
    return ev(1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [13:0] v_unknown();
    return ev(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [13:0] dut_vec();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
            NextPC, RegW, MemW, Branch, ALUOp, Illegal};
  endfunction

  // One clock cycle of stimulus plus the output word expected for it.
  task automatic cyc(input logic rst, input logic mr,
                     input logic [13:0] e, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    reset    = rst;
    MemReady = mr;
    Op       = cur_op;
    Funct    = cur_funct;
    x.vec    = e;
    x.tag    = tag;
    exp_q.push_back(x);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction from FETCH back to FETCH. fw/mw are the stall cycles
  // inserted in the fetch and in the memory access. abort_wb drops reset
  // part-way through the load write-back cycle.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input int fw, input int mw, input bit abort_wb);
    logic [13:0] got;
    cur_op    = op;
    cur_funct = funct;
    for (int i = 0; i < fw; i++) cyc(1'b1, 1'b0, v_fetch(1'b0), "fetch_wait");
    cyc(1'b1, 1'b1, v_fetch(1'b1), "fetch");
    cyc(1'b1, rbit(), v_decode(), "decode");
    case (op)
      2'b01: begin
        cyc(1'b1, rbit(), v_memadr(), "memadr");
        if (funct[0]) begin
          for (int i = 0; i < mw; i++) cyc(1'b1, 1'b0, v_memrd(), "memrd_wait");
          cyc(1'b1, 1'b1, v_memrd(), "memrd");
          cyc(1'b1, rbit(), v_memwb(), "memwb");
          if (abort_wb) begin
            @(negedge clk);
            #2;
            reset = 1'b0;
            #1;
            got = dut_vec();
            n_checks++;
            if (got === v_fetch(1'b0)) n_pass++;
            else $display("FAIL reset_mid_memwb got %b exp %b", got, v_fetch(1'b0));
            cyc(1'b0, rbit(), v_fetch(1'b0), "reset_hold");
          end
        end else begin
          for (int i = 0; i < mw; i++) cyc(1'b1, 1'b0, v_memwr(1'b0), "memwr_wait");
          cyc(1'b1, 1'b1, v_memwr(1'b1), "memwr");
        end
      end
      2'b00: begin
        cyc(1'b1, rbit(), v_exec(funct[5]), "execute");
        cyc(1'b1, rbit(), v_aluwb(), "aluwb");
      end
      2'b10: cyc(1'b1, rbit(), v_branch(), "branch");
      default: ;
    endcase
  endtask

  // Monitor: compares the DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    exp_t x;
    logic [13:0] got;
    cycle_no++;
    if (exp_q.size() > 0) begin
      x   = exp_q.pop_front();
      got = dut_vec();
      n_checks++;
      if (got === x.vec) n_pass++;
      else $display("FAIL %s cycle %0d got %b exp %b", x.tag, cycle_no, got, x.vec);
    end
  end

  initial begin
    int wait_cnt;
    reset     = 1'b0;
    MemReady  = 1'b1;
    cur_op    = 2'b00;
    cur_funct = 6'b0;
    Op        = 2'b00;
    Funct     = 6'b0;

    // Reset held with MemReady high: FETCH outputs with IRWrite/NextPC low.
    cyc(1'b0, 1'b1, v_fetch(1'b0), "reset_state");
    cyc(1'b0, 1'b1, v_fetch(1'b0), "reset_state");

    // Register data-processing right after reset release.
    run_instr(2'b00, 6'b001000, 0, 0, 1'b0);
    // Load with two memory stall cycles.
    run_instr(2'b01, 6'b011001, 0, 2, 1'b0);
    // Store with two stall cycles: MemW only on the completing cycle.
    run_instr(2'b01, 6'b011000, 1, 2, 1'b0);
    // Branch.
    run_instr(2'b10, 6'b000000, 0, 0, 1'b0);
    // Immediate data-processing.
    run_instr(2'b00, 6'b101000, 2, 0, 1'b0);

    // Undefined opcode: trap with Illegal held whatever the inputs do.
    cur_op    = 2'b11;
    cur_funct = 6'b000000;
    cyc(1'b1, 1'b1, v_fetch(1'b1), "fetch");
    cyc(1'b1, rbit(), v_decode(), "decode");
    for (int i = 0; i < 10; i++) begin
      cur_op    = 2'($urandom_range(0, 3));
      cur_funct = 6'($urandom_range(0, 63));
      cyc(1'b1, rbit(), v_unknown(), "unknown_hold");
    end
    cyc(1'b0, 1'b1, v_fetch(1'b0), "unknown_reset");
    cyc(1'b1, 1'b0, v_fetch(1'b0), "fetch_wait");

    // Reset asserted in the middle of the load write-back cycle.
    run_instr(2'b01, 6'b011001, 0, 1, 1'b1);

    // Randomised instruction stream over the legal classes.
    for (int n = 0; n < 40; n++) begin
      run_instr(2'($urandom_range(0, 2)), 6'($urandom_range(0, 63)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Drain the scoreboard within a bounded number of cycles.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mainfsm.md
MAINFSM -- requirements
Module: mainfsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 resets).
REQ-003 SHALL have port Op, input, 2 bits: Instr[27:26].
REQ-004 SHALL have port Funct, input, 6 bits: Instr[25:20].
REQ-005 SHALL have port MemReady, input, 1 bit: memory access completes this cycle.
REQ-006 SHALL have port IRWrite, output, 1 bit: instruction register enable.
REQ-007 SHALL have port AdrSrc, output, 1 bit: address select; 0=PC, 1=ALUOut.
REQ-008 SHALL have port ALUSrcA, output, 2 bits: 00=A, 01=PC, 10/11 never driven.
REQ-009 SHALL have port ALUSrcB, output, 2 bits: 00=WriteData, 01=ExtImm, 10=constant 4, 11 never driven.
REQ-010 SHALL have port ResultSrc, output, 2 bits: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-011 SHALL have ports NextPC, RegW, MemW, Branch, ALUOp, outputs, 1 bit each: unconditioned requests to the condition logic.
REQ-012 SHALL have port Illegal, output, 1 bit: undefined opcode trap.

Function
REQ-013 SHALL implement the Moore states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH and UNKNOWN; all outputs SHALL be a function of state and MemReady only.
REQ-014 SHALL drive 0 on every output not listed for a state.
REQ-015 FETCH SHALL drive AdrSrc=0, ALUSrcA=01, ALUSrcB=10 and ResultSrc=10, and SHALL drive IRWrite=NextPC=MemReady.
REQ-016 FETCH SHALL hold while MemReady=0 and SHALL go to DECODE when MemReady=1.
REQ-017 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10 and ResultSrc=10.
REQ-018 DECODE SHALL branch on Op/Funct: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
REQ-019 MEMADR SHALL drive ALUSrcA=00 and ALUSrcB=01, and SHALL go to MEMRD when Funct[0]=1, else to MEMWR.
REQ-020 MEMRD SHALL drive AdrSrc=1 and ResultSrc=00, SHALL hold while MemReady=0, and SHALL go to MEMWB when MemReady=1.
REQ-021 MEMWB SHALL drive ResultSrc=01 and RegW=1, then go to FETCH.
REQ-022 MEMWR SHALL drive AdrSrc=1, ResultSrc=00 and MemW=MemReady, SHALL hold while MemReady=0, and SHALL go to FETCH when MemReady=1; MemW SHALL be high for exactly one cycle per store.
REQ-023 EXECUTER SHALL drive ALUSrcA=00, ALUSrcB=00 and ALUOp=1; EXECUTEI SHALL drive ALUSrcA=00, ALUSrcB=01 and ALUOp=1; both SHALL go to ALUWB.
REQ-024 ALUWB SHALL drive ResultSrc=00 and RegW=1, then go to FETCH.
REQ-025 BRANCH SHALL drive ALUSrcA=00, ALUSrcB=01, ResultSrc=10 and Branch=1, then go to FETCH.
REQ-026 UNKNOWN SHALL drive Illegal=1 and all other outputs 0, and SHALL remain in UNKNOWN until reset.
REQ-027 Latencies excluding wait cycles SHALL be: LDR 5 cycles, STR 4, data-processing 4, branch 3.
REQ-028 IRWrite, RegW, MemW and NextPC SHALL never be asserted in the same cycle as one another, except IRWrite together with NextPC.

Reset
REQ-029 When reset=0, the block SHALL enter FETCH immediately (asynchronously), including when reset is asserted mid-instruction or during a wait.
REQ-030 While reset=0, all outputs SHALL be FETCH values with MemReady forced to 0 (IRWrite=NextPC=0).
REQ-031 After reset is released, the first rising edge SHALL evaluate the FETCH transition.

Structure
REQ-032 A shared package SHALL hold the state enumeration (4-bit encoding) and the ALUSrcA/ALUSrcB/ResultSrc code constants, reused by datapath and decode.
REQ-033 One sub-module SHALL be used: mainfsm_outdec, the combinational state-to-output decoder; the state register and next-state logic SHALL reside in mainfsm.

Verification
REQ-034 The bench SHALL check: reset=0 then release, MemReady=1, Op=00, Funct=001000 -> FETCH, DECODE, EXECUTER, ALUWB, FETCH, with RegW=1 only in ALUWB.
REQ-035 The bench SHALL check: Op=01, Funct=011001, MemReady low for 2 cycles in MEMRD -> MEMRD held 3 cycles, then MEMWB with ResultSrc=01 and RegW=1.
REQ-036 The bench SHALL check: Op=01, Funct=011000 -> MEMADR, MEMWR, with MemW pulsing exactly once, on the cycle MemReady=1.
REQ-037 The bench SHALL check: Op=10 -> BRANCH, with Branch=1 and ALUSrcB=01 for one cycle, then FETCH; 3 cycles in total.
REQ-038 The bench SHALL check: Op=11 -> UNKNOWN, with Illegal=1 held for 10 cycles and all other outputs 0; then reset=0 -> FETCH.
REQ-039 The bench SHALL check: reset=0 asserted mid-MEMWB -> FETCH immediately, with RegW dropping within the same cycle.
